// File: rtl/neo_frame_sequencer_pkg.sv
// Shared types and constants for the NeoPixel frame sequencer.
package neo_frame_sequencer_pkg;

  localparam int MAX_PIXELS   = 8;
  localparam int MAX_CHANNELS = 4;

  localparam int PIX_W   = 3;
  localparam int CH_W    = 2;
  localparam int LEVEL_W = 8;
  localparam int COUNT_W = 16;

  // Channel ordering as the strand expects it (GRB)
  localparam int CH_G = 0;
  localparam int CH_R = 1;
  localparam int CH_B = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    XMIT,
    GAP
  } seq_state_t;

  // True when (pix, ch) addresses the final load of a frame
  function automatic logic is_last_load(input logic [PIX_W-1:0] pix,
                                        input logic [CH_W-1:0]  ch,
                                        input int               num_pixels,
                                        input int               num_channels);
    return (int'(pix) == num_pixels - 1) && (int'(ch) == num_channels - 1);
  endfunction

endpackage

// File: rtl/neo_frame_sequencer_if.sv
// Bus between pattern logic / strand controller and the frame sequencer.
// master: the side that stages levels, requests frames and acts as controller.
// slave : the sequencer itself.
interface neo_frame_sequencer_if;
  import neo_frame_sequencer_pkg::*;

  // Staging write port
  logic               wr_en;
  logic [PIX_W-1:0]   wr_pixel;
  logic [CH_W-1:0]    wr_color;
  logic [LEVEL_W-1:0] wr_level;

  // Frame requests
  logic               start;
  logic               auto_refresh;

  // Strand controller handshake
  logic               ready_to_load;
  logic               ready_to_send;
  logic               load_color;
  logic [PIX_W-1:0]   pixel_index;
  logic [CH_W-1:0]    color_index;
  logic [LEVEL_W-1:0] color_level;
  logic               send_it;

  // Status
  logic               busy;
  logic               frame_done;
  logic [COUNT_W-1:0] frame_count;

  modport master (
    output wr_en, wr_pixel, wr_color, wr_level,
    output start, auto_refresh,
    output ready_to_load, ready_to_send,
    input  load_color, pixel_index, color_index, color_level, send_it,
    input  busy, frame_done, frame_count
  );

  modport slave (
    input  wr_en, wr_pixel, wr_color, wr_level,
    input  start, auto_refresh,
    input  ready_to_load, ready_to_send,
    output load_color, pixel_index, color_index, color_level, send_it,
    output busy, frame_done, frame_count
  );

endinterface

// File: rtl/neo_frame_sequencer_frame_buffer.sv
// Double-buffered level store: a staged copy written by pattern logic and an
// active copy that feeds the frame in flight. A snapshot copies staged into
// active in one cycle; a write landing in the snapshot cycle is bypassed so
// it is part of the new frame.
module neo_frame_buffer
  import neo_frame_sequencer_pkg::*;
#(
  parameter int NUM_PIXELS   = 5,
  parameter int NUM_CHANNELS = 3
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               wr_en_i,
  input  logic [PIX_W-1:0]   wr_pixel_i,
  input  logic [CH_W-1:0]    wr_color_i,
  input  logic [LEVEL_W-1:0] wr_level_i,
  input  logic               snapshot_i,
  input  logic [PIX_W-1:0]   rd_pixel_i,
  input  logic [CH_W-1:0]    rd_color_i,
  output logic [LEVEL_W-1:0] rd_level_o
);

  logic [LEVEL_W-1:0] staged_q [NUM_PIXELS][NUM_CHANNELS];
  logic [LEVEL_W-1:0] staged_d [NUM_PIXELS][NUM_CHANNELS];
  logic [LEVEL_W-1:0] active_q [NUM_PIXELS][NUM_CHANNELS];
  logic [LEVEL_W-1:0] active_d [NUM_PIXELS][NUM_CHANNELS];

  // Next-state: apply the write (out-of-range addresses match no entry), then
  // snapshot from the post-write staged value so same-cycle writes are kept.
  always_comb begin
    staged_d = staged_q;
    active_d = active_q;
    for (int p = 0; p < NUM_PIXELS; p++) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (wr_en_i && (int'(wr_pixel_i) == p) && (int'(wr_color_i) == c)) begin
          staged_d[p][c] = wr_level_i;
        end
        if (snapshot_i) begin
          active_d[p][c] = staged_d[p][c];
        end
      end
    end
  end

  // Storage registers, cleared on reset
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int p = 0; p < NUM_PIXELS; p++) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
          staged_q[p][c] <= '0;
          active_q[p][c] <= '0;
        end
      end
    end else begin
      staged_q <= staged_d;
      active_q <= active_d;
    end
  end

  // Combinational read of the active copy by (pixel, channel)
  always_comb begin
    rd_level_o = '0;
    for (int p = 0; p < NUM_PIXELS; p++) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if ((int'(rd_pixel_i) == p) && (int'(rd_color_i) == c)) begin
          rd_level_o = active_q[p][c];
        end
      end
    end
  end

endmodule

// File: rtl/neo_frame_sequencer.sv
// NeoPixel frame sequencer: snapshots the staged frame, streams one load per
// (pixel, channel) to the strand controller, issues send_it, waits for the
// transmission to finish, holds a refresh gap and then repeats or idles.
module neo_frame_sequencer
  import neo_frame_sequencer_pkg::*;
#(
  parameter int NUM_PIXELS     = 5,
  parameter int NUM_CHANNELS   = 3,
  parameter int REFRESH_CYCLES = 750000
) (
  input logic                  clock,
  input logic                  reset,
  neo_frame_sequencer_if.slave bus
);

  localparam int GAP_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(REFRESH_CYCLES - 1);

  seq_state_t         state_q, state_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               pend_q, pend_d;
  logic               seen_low_q, seen_low_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic               snapshot;
  logic               done;
  logic               want_frame;
  logic               in_load;
  logic [LEVEL_W-1:0] rd_level;

  neo_frame_buffer #(
    .NUM_PIXELS   (NUM_PIXELS),
    .NUM_CHANNELS (NUM_CHANNELS)
  ) u_buffer (
    .clock_i    (clock),
    .reset_i    (reset),
    .wr_en_i    (bus.wr_en),
    .wr_pixel_i (bus.wr_pixel),
    .wr_color_i (bus.wr_color),
    .wr_level_i (bus.wr_level),
    .snapshot_i (snapshot),
    .rd_pixel_i (pix_q),
    .rd_color_i (ch_q),
    .rd_level_o (rd_level)
  );

  assign want_frame = bus.start || bus.auto_refresh;
  assign in_load    = (state_q == LOAD);

  // Next-state logic: frame FSM, load index walk, gap timer, pending start
  always_comb begin
    state_d    = state_q;
    pix_d      = pix_q;
    ch_d       = ch_q;
    gap_d      = gap_q;
    seen_low_d = seen_low_q;
    count_d    = count_q;
    snapshot   = 1'b0;
    done       = 1'b0;
    // A start seen while busy is remembered (one bit) and served at gap end
    pend_d     = pend_q || (bus.start && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (want_frame) begin
          snapshot = 1'b1;
          pix_d    = '0;
          ch_d     = '0;
          state_d  = LOAD;
        end
      end

      LOAD: begin
        if (bus.ready_to_load) begin
          if (is_last_load(pix_q, ch_q, NUM_PIXELS, NUM_CHANNELS)) begin
            state_d = SEND;
          end else if (int'(ch_q) == NUM_CHANNELS - 1) begin
            ch_d  = '0;
            pix_d = pix_q + PIX_W'(1);
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end
      end

      SEND: begin
        if (bus.ready_to_send) begin
          seen_low_d = 1'b0;
          state_d    = XMIT;
        end
      end

      XMIT: begin
        // ready_to_load falls when the controller starts shifting and rises
        // again once the whole strand has been clocked out
        if (!bus.ready_to_load) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q) begin
          done    = 1'b1;
          count_d = count_q + COUNT_W'(1);
          gap_d   = '0;
          state_d = GAP;
        end
      end

      GAP: begin
        if (gap_q == GAP_LAST) begin
          if (want_frame || pend_q) begin
            snapshot = 1'b1;
            pix_d    = '0;
            ch_d     = '0;
            state_d  = LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    if (snapshot) begin
      pend_d = 1'b0;
    end
  end

  // State and counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pix_q      <= '0;
      ch_q       <= '0;
      gap_q      <= '0;
      pend_q     <= 1'b0;
      seen_low_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pix_q      <= pix_d;
      ch_q       <= ch_d;
      gap_q      <= gap_d;
      pend_q     <= pend_d;
      seen_low_q <= seen_low_d;
      count_q    <= count_d;
    end
  end

  // Load fields are forced to zero outside LOAD so the controller only ever
  // sees meaningful index/level values alongside the strobe.
  assign bus.load_color  = in_load;
  assign bus.pixel_index = in_load ? pix_q : '0;
  assign bus.color_index = in_load ? ch_q : '0;
  assign bus.color_level = in_load ? rd_level : '0;
  assign bus.send_it     = (state_q == SEND);
  assign bus.busy        = (state_q != IDLE);
  assign bus.frame_done  = done;
  assign bus.frame_count = count_q;

endmodule
